// File: rtl/bdd_pkg.sv
// bdd_pkg: shared constants and types for the BDD accelerator front end.
package bdd_pkg;
  localparam int FEAT_W = 8;
  localparam int NUM_FEAT = 5;
  typedef logic [NUM_FEAT-1:0][FEAT_W-1:0] feat_vec_t;
  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} asm_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with wrap-bit pointers and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push) + (AW+1)'(0);
      rd_ptr <= rd_ptr + AW'(pop) + (AW+1)'(0);
    end
endmodule

// File: rtl/feature_loader.sv
// feature_loader: frames a byte-serial feature stream into ID-tagged vectors
// and buffers them in a FWFT FIFO for the tree walker.
module feature_loader #(
  parameter int NUM_FEAT = bdd_pkg::NUM_FEAT,
  parameter int FEAT_W = bdd_pkg::FEAT_W,
  parameter int DEPTH = 4,
  parameter int ID_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_sop,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] m_feat,
  output logic [ID_W-1:0]            m_id,
  output logic                       frame_err,
  output logic [7:0]                 err_count,
  output logic [$clog2(DEPTH):0]     occupancy
);
  import bdd_pkg::*;
  localparam int IW = $clog2(NUM_FEAT);
  localparam int VW = NUM_FEAT * FEAT_W;
  asm_state_t state;
  logic [IW-1:0] idx;
  logic [ID_W-1:0] id;
  logic [NUM_FEAT-1:0][FEAT_W-1:0] feat, nxt;
  logic [ID_W+VW-1:0] rdata;
  logic accept, last, push, pop, err, full, empty;
  assign s_ready = !full;
  assign accept = s_valid && s_ready;
  assign last = idx == IW'(NUM_FEAT - 1);
  assign push = accept && state == COLLECT && !s_sop && last;
  assign pop = !empty && m_ready;
  assign err = accept && (state == IDLE ? !s_sop : s_sop);
  assign m_valid = !empty;
  assign m_feat = empty ? '0 : rdata[VW-1:0];
  assign m_id = empty ? '0 : rdata[ID_W+VW-1:VW];
  // The vector being completed includes the byte on the bus this cycle.
  always_comb begin
    nxt = feat;
    nxt[s_sop ? '0 : idx] = s_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      id <= '0;
      feat <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= err;
      err_count <= err_count + 8'(err && err_count != 8'hFF);
      if (accept && (s_sop || state == COLLECT)) feat <= nxt;
      if (accept && s_sop) begin
        state <= COLLECT;
        idx <= IW'(1);
      end else if (accept && state == COLLECT) begin
        state <= last ? IDLE : COLLECT;
        idx <= last ? '0 : idx + 1'b1;
        id <= id + ID_W'(last);
      end
    end
  sync_fifo #(.WIDTH(ID_W + VW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata({id, nxt}),
    .pop(pop),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
endmodule
